scan_chain_ctrl: RTL and testbench

- Drives the datapath scan interface (SDI, Test) and collects SDO from the other end of the chain.
- Host side: loads a CHAIN_LEN-bit word and starts one transaction.
- The block serially shifts the word into the chain and captures the bits that emerge at the same time.
- Optionally releases Test for a functional capture window, then unloads the captured chain state.
- Sits between the test host/bench and the datapath scan pins.

---
 rtl/scan_pkg.sv | 17 +
 rtl/scan_shift_buf.sv | 30 +++
 rtl/scan_chain_ctrl.sv | 126 ++++++++++++
 tb/tb_scan_chain_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state encoding and counter sizing for the scan chain controller
package scan_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      CAPT,
      UNLOAD,
      DONE
   } scan_state_t;

   // Wide enough for the longest count held in any single state.
   function automatic int scan_cnt_w(input int chain_len, input int cap_cycles);
      return $clog2(chain_len + cap_cycles + 1);
   endfunction

endpackage

// File: rtl/scan_shift_buf.sv
// rtl/scan_shift_buf.sv - parallel-load / serial-shift buffer, LSB leaves first
module scan_shift_buf #(
   parameter int CHAIN_LEN = 16
) (
   input  logic                 Clock,
   input  logic                 nReset,
   input  logic                 i_load,
   input  logic                 i_shift,
   input  logic [CHAIN_LEN-1:0] i_din,
   input  logic                 i_sin,
   output logic                 o_sout,
   output logic [CHAIN_LEN-1:0] o_q
);

   logic [CHAIN_LEN-1:0] r_buf;

   always_ff @(posedge Clock) begin
      if (!nReset) begin
         r_buf <= '0;
      end else if (i_load) begin
         r_buf <= i_din;
      end else if (i_shift) begin
         r_buf <= {i_sin, r_buf[CHAIN_LEN-1:1]};
      end
   end

   assign o_sout = r_buf[0];
   assign o_q    = r_buf;

endmodule

// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - scan chain load/capture/unload sequencer with registered scan enable
module scan_chain_ctrl
   import scan_pkg::*;
#(
   parameter int CHAIN_LEN  = 16,
   parameter int CAP_CYCLES = 1
) (
   input  logic                 Clock,
   input  logic                 nReset,
   input  logic                 Start,
   input  logic                 Capture,
   input  logic [CHAIN_LEN-1:0] ScanData,
   output logic [CHAIN_LEN-1:0] ScanOut,
   output logic                 Busy,
   output logic                 Done,
   output logic                 Test,
   output logic                 SDI,
   input  logic                 SDO
);

   localparam int                CNT_W      = scan_cnt_w(CHAIN_LEN, CAP_CYCLES);
   localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0]  LAST_CAPT  = CNT_W'(CAP_CYCLES - 1);

   scan_state_t          r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_capt_q;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_test;
   logic [CHAIN_LEN-1:0] r_scan_out;

   logic                 w_load;
   logic                 w_shift;
   logic                 w_sout;
   logic [CHAIN_LEN-1:0] w_q;

   assign w_load  = (r_state == IDLE) && Start;
   assign w_shift = (r_state == SHIFT) || (r_state == UNLOAD);

   scan_shift_buf #(
      .CHAIN_LEN (CHAIN_LEN)
   ) u_buf (
      .Clock   (Clock),
      .nReset  (nReset),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_din   (ScanData),
      .i_sin   (SDO),
      .o_sout  (w_sout),
      .o_q     (w_q)
   );

   // The buffer keeps captured data after DONE, so SDI is gated to SHIFT only.
   assign SDI = (r_state == SHIFT) && w_sout;

   always_ff @(posedge Clock) begin
      if (!nReset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_capt_q   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_test     <= 1'b0;
         r_scan_out <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (Start) begin
                  r_cnt    <= '0;
                  r_capt_q <= Capture;
                  r_busy   <= 1'b1;
                  r_test   <= 1'b1;
                  r_state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (r_cnt == LAST_SHIFT) begin
                  r_cnt  <= '0;
                  r_test <= 1'b0;
                  if (r_capt_q) begin
                     r_state <= CAPT;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            CAPT: begin
               if (r_cnt == LAST_CAPT) begin
                  r_cnt   <= '0;
                  r_test  <= 1'b1;
                  r_state <= UNLOAD;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            UNLOAD: begin
               if (r_cnt == LAST_SHIFT) begin
                  r_cnt   <= '0;
                  r_test  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               r_scan_out <= w_q;
               r_busy     <= 1'b0;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ScanOut = r_scan_out;
   assign Busy    = r_busy;
   assign Done    = r_done;
   assign Test    = r_test;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb/tb_scan_chain_ctrl.sv - directed bench with a behavioural 16-flop scan chain
module tb_scan_chain_ctrl;

   logic        Clock;
   logic        nReset;
   logic        Start;
   logic        Capture;
   logic [15:0] ScanData;
   logic [15:0] ScanOut;
   logic        Busy;
   logic        Done;
   logic        Test;
   logic        SDI;
   logic        SDO;

   int passed;
   int total;

   // Chain word kept in ScanData bit order: word[i] is chain position 15-i.
   logic [15:0] chain;
   logic        preset_req;
   logic        sdo_force;

   int          dc;
   int          th;
   int          nd;
   logic [63:0] tl;
   logic [15:0] ss;

   scan_chain_ctrl #(
      .CHAIN_LEN  (16),
      .CAP_CYCLES (1)
   ) dut (
      .Clock    (Clock),
      .nReset   (nReset),
      .Start    (Start),
      .Capture  (Capture),
      .ScanData (ScanData),
      .ScanOut  (ScanOut),
      .Busy     (Busy),
      .Done     (Done),
      .Test     (Test),
      .SDI      (SDI),
      .SDO      (SDO)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   always @(posedge Clock) begin
      if (preset_req)
         chain <= 16'h0000;
      else if (Test)
         chain <= {SDI, chain[15:1]};
      else if (Busy && !Done)
         chain <= chain + 16'h0001;
   end

   assign SDO = sdo_force ? 1'b1 : chain[0];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Called at a negedge; Start is driven in that cycle (cycle 1). Returns at the Done cycle.
   task automatic run_txn(input logic [15:0] data, input logic capt, input logic hammer,
                          output int done_cyc, output int test_hi, output logic [63:0] tlog,
                          output logic [15:0] sdi_seq, output int n_done);
      int cyc;
      int k;
      done_cyc = 0;
      test_hi  = 0;
      tlog     = '0;
      sdi_seq  = '0;
      n_done   = 0;
      k        = 0;
      ScanData = data;
      Capture  = capt;
      Start    = 1'b1;
      cyc      = 1;
      while (done_cyc == 0 && cyc < 200) begin
         @(negedge Clock);
         cyc++;
         if (Test) begin
            test_hi++;
            if (k < 16) sdi_seq[k] = SDI;
            k++;
         end
         tlog = {tlog[62:0], Test};
         if (Done) begin
            n_done++;
            done_cyc = cyc;
         end
         Start = hammer && !Done;
         if (hammer) ScanData = ~ScanData;
      end
      Start = 1'b0;
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge Clock);
         if (Done) n++;
      end
   endtask

   initial begin
      passed     = 0;
      total      = 0;
      nReset     = 1'b0;
      Start      = 1'b0;
      Capture    = 1'b0;
      ScanData   = 16'h0000;
      preset_req = 1'b1;
      sdo_force  = 1'b0;
      repeat (3) @(negedge Clock);
      check("reset_scanout", 64'(ScanOut), 64'h0);
      check("reset_busy",    64'(Busy),    64'h0);
      check("reset_done",    64'(Done),    64'h0);
      check("reset_test",    64'(Test),    64'h0);
      check("reset_sdi",     64'(SDI),     64'h0);
      nReset     = 1'b1;
      preset_req = 1'b0;

      // Reset mid-shift at cnt=5
      @(negedge Clock);
      ScanData = 16'hBEEF;
      Capture  = 1'b0;
      Start    = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      repeat (5) @(negedge Clock);
      nReset = 1'b0;
      @(negedge Clock);
      check("abort_test",    64'(Test),    64'h0);
      check("abort_busy",    64'(Busy),    64'h0);
      check("abort_scanout", 64'(ScanOut), 64'h0);
      check("abort_done",    64'(Done),    64'h0);
      nReset = 1'b1;
      count_done(40, nd);
      check("abort_no_done", 64'(nd), 64'h0);

      // Plain shift of 0xA5C3 into an all-zero chain
      preset_req = 1'b1;
      @(negedge Clock);
      preset_req = 1'b0;
      run_txn(16'hA5C3, 1'b0, 1'b0, dc, th, tl, ss, nd);
      check("t2_done_cycle", 64'(dc), 64'd18);
      check("t2_test_high",  64'(th), 64'd16);
      check("t2_test_log",   tl, {47'b0, 16'hFFFF, 1'b0});
      @(negedge Clock);
      check("t2_scanout",    64'(ScanOut), 64'h0000);
      check("t2_chain",      64'(chain),   64'hA5C3);

      // Back-to-back round trip
      run_txn(16'h1234, 1'b0, 1'b0, dc, th, tl, ss, nd);
      check("t3_done_cycle", 64'(dc), 64'd18);
      @(negedge Clock);
      check("t3_scanout",    64'(ScanOut), 64'hA5C3);
      check("t3_chain",      64'(chain),   64'h1234);

      // Capture transaction: chain increments during the functional window
      run_txn(16'h00FF, 1'b1, 1'b0, dc, th, tl, ss, nd);
      check("t4_done_cycle", 64'(dc), 64'd35);
      check("t4_test_log",   tl, {30'b0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0});
      @(negedge Clock);
      check("t4_scanout",    64'(ScanOut), 64'h0100);
      check("t4_chain",      64'(chain),   64'h0000);

      // Start hammered while busy: only the first request counts
      run_txn(16'h3C5A, 1'b0, 1'b1, dc, th, tl, ss, nd);
      check("t5_done_cycle", 64'(dc), 64'd18);
      check("t5_done_count", 64'(nd), 64'd1);
      count_done(40, nd);
      check("t5_no_extra",   64'(nd), 64'h0);
      check("t5_busy_idle",  64'(Busy), 64'h0);
      check("t5_scanout",    64'(ScanOut), 64'h0000);
      check("t5_chain",      64'(chain),   64'h3C5A);
      run_txn(16'h0000, 1'b0, 1'b0, dc, th, tl, ss, nd);
      @(negedge Clock);
      check("t5_readback",   64'(ScanOut), 64'h3C5A);

      // SDO stuck high; SDI must replay ScanData LSB first
      sdo_force = 1'b1;
      run_txn(16'h5A5A, 1'b0, 1'b0, dc, th, tl, ss, nd);
      check("t6_done_cycle", 64'(dc), 64'd18);
      check("t6_sdi_seq",    64'(ss), 64'h5A5A);
      @(negedge Clock);
      check("t6_scanout",    64'(ScanOut), 64'hFFFF);
      sdo_force = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
